dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Multi-cycle data-memory responder for the RV32I core. It sits on the data side of the load/store path, serving byte, halfword and word accesses selected by funct3. It replaces the zero-latency word-only data RAM with a request/ready handshake and a programmable wait-state count, so the core can be moved to stalling memory.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words; power of two
- LATENCY, 2, wait-state cycles between request capture and response; range 0..15

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  1  access request; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- funct3  in  3  access size and sign (RV32I load/store encoding)
- adr  in  32  byte address
- wd  in  32  store data, right-aligned
- rd  out  32  load data, extended to 32 bits; valid only while ready=1, otherwise 0
- ready  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after capture through the ready cycle
- err  out  1  access fault, coincident with ready; present only with DMEM_MISALIGN_TRAP_EN

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE:** when req=1, capture adr, we, funct3 and wd, and load the counter with LATENCY. Go to WAIT, or to RESP if LATENCY=0.
- **WAIT:** the counter decrements each cycle. When the counter reaches 1, go to RESP (N cycles spent in WAIT in total).
- **RESP:** ready=1 for exactly one cycle, then go to IDLE unconditionally. req is ignored in WAIT and RESP.
- Memory is accessed on the edge that enters RESP.
  - For loads, rd is registered from the addressed lanes.
  - For stores, the enabled byte lanes are written and rd stays 0.
- Word index is adr[$clog2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Store lanes:
  - sb (000): lane adr[1:0], data wd[7:0]
  - sh (001): lanes {adr[1],0} and {adr[1],1}, data wd[15:0]
  - sw (010): all four lanes
- Loads:
  - lb (000): sign-extended byte at adr[1:0]
  - lh (001): sign-extended halfword at adr[1]
  - lw (010): full word
  - lbu (100): zero-extended byte
  - lhu (101): zero-extended halfword
- Invalid funct3 (011, 110, 111): no write, rd=0.
- Reset:
  - state=IDLE, counter=0, rd=0, ready=0, busy=0, err=0
  - RAM contents are not reset.
- Reset mid-operation: the access is abandoned and no write occurs. Reset has priority over the memory write on the same edge.

## Timing
- req=1 in IDLE during cycle 0 → busy=1 in cycles 1..N+1, ready=1 and rd valid in cycle N+1, back in IDLE in cycle N+2.
- Minimum access period is N+2 cycles. With req held high continuously, ready pulses every N+2 cycles.
- A store is visible to a load captured in any later cycle.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A fault is an sh with adr[0]=1, an sw with adr[1:0]≠0, or an invalid funct3.
  - On a fault the write is suppressed, rd=0, and err=1 in the ready cycle.
  - Timing is unchanged.
- Not defined:
  - No err port.
  - Low address bits below the access size are ignored: sh uses adr[1] only; sw and lw are word-aligned.

## Structure
- Package dmem_pkg holds:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101
  - the typedef enum for states IDLE, WAIT, RESP
- One combinational sub-module, lane_align, produces:
  - the 4-bit byte enable and the lane-replicated store data from funct3, adr[1:0] and wd
  - the extracted, extended load data from the RAM word
  - the misalign/invalid flag

## Test plan
1. LATENCY=2: sw 0x12345678 to 0x64, then lw 0x64 → ready in cycle 3 of each access, rd=0x12345678, busy high cycles 1–3.
2. sb wd=0x80 to 0x65 → lw 0x64 returns 0x12348078; lb 0x65 → 0xFFFFFF80; lbu 0x65 → 0x00000080.
3. sh wd=0xBEEF to 0x66 → lw 0x64 returns 0xBEEF8078; lh 0x66 → 0xFFFFBEEF; lhu 0x66 → 0x0000BEEF.
4. sw 0xDEADBEEF to 0x70 (word previously 0) with reset pulsed during WAIT → no ready pulse, all outputs 0 next cycle, later lw 0x70 → 0x00000000.
5. sw 0xCAFEF00D to 0x62:
   - with DMEM_MISALIGN_TRAP_EN: err=1 with ready, word 0x60 unchanged
   - without: word 0x60 reads 0xCAFEF00D
6. LATENCY=0, DEPTH=256, req held high: ready every 2nd cycle; sw 0x11 to 0x400 then lw 0x000 → 0x00000011 (wrap-around).

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 encodings, FSM state type and a funct3 legality helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // 011, 110 and 111 are not RV32I load/store sizes.
  function automatic logic f3_valid(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bundle between the core load/store path and dmem_ctrl.
// Latency: n/a (wiring only); the err signal exists only when DMEM_MISALIGN_TRAP_EN is defined.
// Backpressure: core holds req until it sees ready; the responder ignores req while busy.
// Signals: req/we/funct3/adr/wd (core -> memory), rd/ready/busy[/err] (memory -> core).
interface dmem_ctrl_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] adr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        busy;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        err;

  modport master (output req, we, funct3, adr, wd, input rd, ready, busy, err);
  modport slave  (input req, we, funct3, adr, wd, output rd, ready, busy, err);
`else
  modport master (output req, we, funct3, adr, wd, input rd, ready, busy);
  modport slave  (input req, we, funct3, adr, wd, output rd, ready, busy);
`endif
endinterface

// File: rtl/dmem_ctrl_lane_align.sv
// lane_align: byte-lane steering for stores and extraction/extension for loads.
// Latency: purely combinational.
// Backpressure: none. Macro DMEM_MISALIGN_TRAP_EN adds misalignment to the fault flag.
// Ports: funct3, adr_lo (byte offset), wd, ram_word in; be, st_data, ld_data, fault out.
module lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  adr_lo,
  input  logic [31:0] wd,
  input  logic [31:0] ram_word,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        fault
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ram_word[{adr_lo, 3'b000} +: 8];
    ld_half = adr_lo[1] ? ram_word[31:16] : ram_word[15:0];
    be      = 4'b0000;
    st_data = wd;
    ld_data = '0;
    case (funct3)
      F3_B: begin
        be      = 4'b0001 << adr_lo;
        st_data = {4{wd[7:0]}};
        ld_data = {{24{ld_byte[7]}}, ld_byte};
      end
      F3_H: begin
        // adr_lo[0] is ignored: the halfword always sits on an even lane pair.
        be      = adr_lo[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wd[15:0]}};
        ld_data = {{16{ld_half[15]}}, ld_half};
      end
      F3_W: begin
        be      = 4'b1111;
        ld_data = ram_word;
      end
      F3_BU: ld_data = {24'b0, ld_byte};
      F3_HU: ld_data = {16'b0, ld_half};
      default: ;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault = !f3_valid(funct3) ||
                 ((funct3 == F3_H) && adr_lo[0]) ||
                 ((funct3 == F3_W) && (adr_lo != 2'b00));
`else
  assign fault = !f3_valid(funct3);
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle RV32I data-memory responder with LATENCY wait states (IDLE/WAIT/RESP).
// Latency: request captured in cycle 0, one-cycle ready pulse with rd in cycle LATENCY+1.
// Backpressure: req is only sampled in IDLE; busy is high from capture+1 through the ready cycle.
// Ports: clk, reset (sync, active high), bus (dmem_ctrl_if.slave).
// Macro DMEM_MISALIGN_TRAP_EN: faults (misaligned sh/sw, bad funct3) suppress the write and raise err.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  dmem_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [2:0]  cap_f3;
  logic [31:0] cap_adr;
  logic [31:0] cap_wd;

  logic [31:0] mem [DEPTH];

  logic        acc_we;
  logic [2:0]  acc_f3;
  logic [31:0] acc_adr;
  logic [31:0] acc_wd;
  logic [AW-1:0] idx;
  logic [31:0] ram_word;
  logic [3:0]  be;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        fault;
  logic        enter_resp;
  logic        do_write;
  logic        unused_adr;

  // With LATENCY=0 the memory is accessed on the capture edge itself, so the
  // access fields come straight from the bus while IDLE and from the capture
  // registers otherwise.
  always_comb begin
    if (state == IDLE) begin
      acc_we  = bus.we;
      acc_f3  = bus.funct3;
      acc_adr = bus.adr;
      acc_wd  = bus.wd;
    end else begin
      acc_we  = cap_we;
      acc_f3  = cap_f3;
      acc_adr = cap_adr;
      acc_wd  = cap_wd;
    end
  end

  assign idx        = acc_adr[AW+1:2];
  assign unused_adr = ^acc_adr[31:AW+2];
  assign ram_word   = mem[idx];

  always_comb begin
    enter_resp = 1'b0;
    case (state)
      IDLE:    enter_resp = bus.req && (LATENCY == 0);
      WAIT:    enter_resp = (cnt == 4'd1);
      default: enter_resp = 1'b0;
    endcase
  end

  // Reset wins over a write landing on the same edge.
  assign do_write = enter_resp && acc_we && !fault && !reset;

  lane_align u_lane_align (
    .funct3   (acc_f3),
    .adr_lo   (acc_adr[1:0]),
    .wd       (acc_wd),
    .ram_word (ram_word),
    .be       (be),
    .st_data  (st_data),
    .ld_data  (ld_data),
    .fault    (fault)
  );

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      bus.rd    <= '0;
      bus.ready <= 1'b0;
      bus.busy  <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      bus.err   <= 1'b0;
`endif
    end else begin
      // rd/ready/err are single-cycle: cleared unless this edge enters RESP.
      bus.ready <= 1'b0;
      bus.rd    <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      bus.err   <= 1'b0;
`endif
      if (enter_resp) begin
        bus.ready <= 1'b1;
        bus.rd    <= (acc_we || fault) ? '0 : ld_data;
`ifdef DMEM_MISALIGN_TRAP_EN
        bus.err   <= fault;
`endif
      end
      case (state)
        IDLE: begin
          if (bus.req) begin
            cap_we   <= bus.we;
            cap_f3   <= bus.funct3;
            cap_adr  <= bus.adr;
            cap_wd   <= bus.wd;
            cnt      <= 4'(LATENCY);
            bus.busy <= 1'b1;
            state    <= enter_resp ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (enter_resp) state <= RESP;
        end
        RESP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed plus randomized bench for dmem_ctrl (LATENCY=2 and LATENCY=0 instances).
// Expected values come from a word-array reference model driven by the access rules.
// Honours DMEM_MISALIGN_TRAP_EN for the err port and fault expectations.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_ctrl_if bus2();
  dmem_ctrl_if bus0();

  dmem_ctrl #(.DEPTH(256), .LATENCY(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
  dmem_ctrl #(.DEPTH(256), .LATENCY(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

  int checks   = 0;
  int failures = 0;

  // ref_mem[0] mirrors the LATENCY=2 instance, ref_mem[1] the LATENCY=0 one.
  logic [31:0] ref_mem [2][256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int d, input bit w, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wdat,
                                output logic [31:0] exp_rd, output bit exp_err);
    int unsigned widx = (a / 4) % 256;
    int unsigned boff = a % 4;
    int unsigned hsh  = 16 * ((a / 2) % 2);
    logic [31:0] word = ref_mem[d][widx];
    logic [7:0]  b8;
    logic [15:0] h16;
    bit bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (f3 == F3_H && (a % 2) != 0) bad = 1'b1;
    if (f3 == F3_W && boff != 0) bad = 1'b1;
`endif
    exp_rd  = 32'h0;
    exp_err = bad;
    if (bad) return;
    b8  = 8'(word >> (8 * boff));
    h16 = 16'(word >> hsh);
    if (w) begin
      case (f3)
        F3_B: word = (word & ~(32'hFF << (8 * boff))) | ({24'h0, wdat[7:0]} << (8 * boff));
        F3_H: word = (word & ~(32'hFFFF << hsh)) | ({16'h0, wdat[15:0]} << hsh);
        F3_W: word = wdat;
        default: ;
      endcase
      ref_mem[d][widx] = word;
    end else begin
      case (f3)
        F3_B:  exp_rd = 32'($signed(b8));
        F3_H:  exp_rd = 32'($signed(h16));
        F3_W:  exp_rd = word;
        F3_BU: exp_rd = {24'h0, b8};
        F3_HU: exp_rd = {16'h0, h16};
        default: ;
      endcase
    end
  endfunction

  // One access on the LATENCY=2 instance with full cycle-by-cycle timing checks.
  task automatic acc2(input bit w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] obs_rd, output bit obs_err);
    logic [31:0] er;
    bit ee;
    model(0, w, f3, a, d, er, ee);
    obs_err = 1'b0;
    @(negedge clk);
    bus2.req = 1'b1; bus2.we = w; bus2.funct3 = f3; bus2.adr = a; bus2.wd = d;
    @(posedge clk); #1;
    bus2.req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      chk("busy", 32'(bus2.busy), 32'h1);
      chk("ready", 32'(bus2.ready), (k == 3) ? 32'h1 : 32'h0);
      chk("rd", bus2.rd, (k == 3) ? er : 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("err", 32'(bus2.err), (k == 3) ? 32'(ee) : 32'h0);
      if (k == 3) obs_err = bus2.err;
`endif
      if (k == 3) obs_rd = bus2.rd;
    end
    @(posedge clk); #1;
    chk("idle_busy", 32'(bus2.busy), 32'h0);
    chk("idle_ready", 32'(bus2.ready), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] obs, e0, r, a;
    bit oe, ee0, w;
    logic [2:0] f3;
    logic [2:0] ld_f3s [8] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU, 3'b011, 3'b110, 3'b111};
    logic [2:0] st_f3s [3] = '{F3_B, F3_H, F3_W};

    reset = 1'b1;
    bus2.req = 0; bus2.we = 0; bus2.funct3 = 0; bus2.adr = 0; bus2.wd = 0;
    bus0.req = 0; bus0.we = 0; bus0.funct3 = 0; bus0.adr = 0; bus0.wd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd2", bus2.rd, 32'h0);
    chk("rst_ready2", 32'(bus2.ready), 32'h0);
    chk("rst_busy2", 32'(bus2.busy), 32'h0);
    chk("rst_rd0", bus0.rd, 32'h0);
    chk("rst_ready0", 32'(bus0.ready), 32'h0);
    chk("rst_busy0", 32'(bus0.busy), 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("rst_err2", 32'(bus2.err), 32'h0);
`endif
    reset = 1'b0;

    // Give every word the tests read a known value.
    acc2(1, F3_W, 32'h60, 32'h0, obs, oe);
    acc2(1, F3_W, 32'h64, 32'h0, obs, oe);
    acc2(1, F3_W, 32'h70, 32'h0, obs, oe);
    for (int i = 0; i < 16; i++) acc2(1, F3_W, 32'h100 + 4 * i, 32'h0, obs, oe);

    // Word store/load round trip.
    acc2(1, F3_W, 32'h64, 32'h12345678, obs, oe);
    acc2(0, F3_W, 32'h64, 32'h0, obs, oe);
    chk("t1_lw", obs, 32'h12345678);

    // Byte store, then signed/unsigned byte loads.
    acc2(1, F3_B, 32'h65, 32'h80, obs, oe);
    acc2(0, F3_W, 32'h64, 32'h0, obs, oe);
    chk("t2_lw", obs, 32'h12348078);
    acc2(0, F3_B, 32'h65, 32'h0, obs, oe);
    chk("t2_lb", obs, 32'hFFFFFF80);
    acc2(0, F3_BU, 32'h65, 32'h0, obs, oe);
    chk("t2_lbu", obs, 32'h00000080);

    // Halfword store, then signed/unsigned halfword loads.
    acc2(1, F3_H, 32'h66, 32'hBEEF, obs, oe);
    acc2(0, F3_W, 32'h64, 32'h0, obs, oe);
    chk("t3_lw", obs, 32'hBEEF8078);
    acc2(0, F3_H, 32'h66, 32'h0, obs, oe);
    chk("t3_lh", obs, 32'hFFFFBEEF);
    acc2(0, F3_HU, 32'h66, 32'h0, obs, oe);
    chk("t3_lhu", obs, 32'h0000BEEF);

    // Reset during WAIT abandons the store.
    @(negedge clk);
    bus2.req = 1'b1; bus2.we = 1'b1; bus2.funct3 = F3_W; bus2.adr = 32'h70; bus2.wd = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus2.req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t4_ready", 32'(bus2.ready), 32'h0);
    chk("t4_busy", 32'(bus2.busy), 32'h0);
    chk("t4_rd", bus2.rd, 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t4_no_ready", 32'(bus2.ready), 32'h0);
    end
    acc2(0, F3_W, 32'h70, 32'h0, obs, oe);
    chk("t4_lw", obs, 32'h00000000);

    // Misaligned word store.
    acc2(1, F3_W, 32'h62, 32'hCAFEF00D, obs, oe);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("t5_err", 32'(oe), 32'h1);
    acc2(0, F3_W, 32'h60, 32'h0, obs, oe);
    chk("t5_lw", obs, 32'h00000000);
`else
    acc2(0, F3_W, 32'h60, 32'h0, obs, oe);
    chk("t5_lw", obs, 32'hCAFEF00D);
`endif

    // Random traffic confined to words 64..79, upper address bits random (wrap).
    for (int i = 0; i < 80; i++) begin
      r  = $urandom();
      a  = {r[31:10], 4'b0100, r[5:0]};
      w  = ($urandom_range(0, 1) == 1);
      f3 = w ? st_f3s[$urandom_range(0, 2)] : ld_f3s[$urandom_range(0, 7)];
      acc2(w, f3, a, $urandom(), obs, oe);
    end

    // LATENCY=0 with req held high: ready every second cycle, address wrap.
    @(negedge clk);
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.funct3 = F3_W; bus0.adr = 32'h400; bus0.wd = 32'h11;
    model(1, 1'b1, F3_W, 32'h400, 32'h11, e0, ee0);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      chk("t6_ready", 32'(bus0.ready), (cyc % 2 == 1) ? 32'h1 : 32'h0);
      chk("t6_busy", 32'(bus0.busy), (cyc % 2 == 1) ? 32'h1 : 32'h0);
      chk("t6_rd", bus0.rd, (cyc % 2 == 1) ? e0 : 32'h0);
      if (cyc >= 3 && cyc % 2 == 1) chk("t6_wrap", bus0.rd, 32'h11);
      if (cyc % 2 == 1) begin
        @(negedge clk);
        bus0.we = 1'b0; bus0.funct3 = F3_W; bus0.adr = 32'h0;
        model(1, 1'b0, F3_W, 32'h0, 32'h0, e0, ee0);
      end
    end
    bus0.req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
